// File: rtl/sh2_sci_tx_pkg.sv
// Shared types and helpers for the SH-2 SCI transmitter.
// The optional multiprocessor bit (SCI_TX_MP_EN) is handled in the top; nothing here depends on it.
package sh2_sci_tx_pkg;

  typedef struct packed {
    logic       ca;
    logic       chr;
    logic       pe;
    logic       oe;
    logic       stop;
    logic       mp;
    logic [1:0] cks;
  } SMR_t;

  typedef struct packed {
    logic       tie;
    logic       rie;
    logic       te;
    logic       re;
    logic       mpie;
    logic       teie;
    logic [1:0] cke;
  } SCR_t;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, MPB, STOP} SCI_TxState_t;

  localparam int unsigned BIT_OS = 64;

  function automatic logic [6:0] SCI_PrescaleLen(input logic [1:0] cks);
    case (cks)
      2'd0:    return 7'd1;
      2'd1:    return 7'd4;
      2'd2:    return 7'd16;
      default: return 7'd64;
    endcase
  endfunction

  // Even parity over the data bits actually sent; odd flips it.
  function automatic logic SCI_Parity(input logic [7:0] data, input logic chr, input logic odd);
    return (^(chr ? {1'b0, data[6:0]} : data)) ^ odd;
  endfunction

endpackage

// File: rtl/sh2_sci_baudgen.sv
// Bit-period generator: prescaler x (BRR+1) x 64, one CE-qualified BIT_TICK per bit period.
// restart zeroes the chain so the following bit lasts exactly one full period.
module sh2_sci_baudgen
  import sh2_sci_tx_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE,
  input  logic [1:0] CKS,
  input  logic [7:0] BRR,
  input  logic       restart,
  output logic       BIT_TICK
);

  logic [5:0] pre_cnt;
  logic [7:0] brr_cnt;
  logic [5:0] os_cnt;
  logic       pre_last, brr_last, os_last;

  // >= keeps the chain from running away if BRR/CKS shrink under a live count
  assign pre_last = ({1'b0, pre_cnt} >= SCI_PrescaleLen(CKS) - 7'd1);
  assign brr_last = (brr_cnt >= BRR);
  assign os_last  = (os_cnt == 6'(BIT_OS - 1));
  assign BIT_TICK = CE & pre_last & brr_last & os_last;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_cnt <= '0;
      brr_cnt <= '0;
      os_cnt  <= '0;
    end else if (restart) begin
      pre_cnt <= '0;
      brr_cnt <= '0;
      os_cnt  <= '0;
    end else if (CE) begin
      if (!pre_last) begin
        pre_cnt <= pre_cnt + 6'd1;
      end else begin
        pre_cnt <= '0;
        if (!brr_last) begin
          brr_cnt <= brr_cnt + 8'd1;
        end else begin
          brr_cnt <= '0;
          os_cnt  <= os_cnt + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/sh2_sci_tx.sv
// SH-2 SCI asynchronous transmitter: frame FSM, shift register, TDRE/TEND flags, TXI/TEI requests.
// Define SCI_TX_MP_EN to honour SMR.MP and send SSR.MPBT as a multiprocessor bit.
module sh2_sci_tx
  import sh2_sci_tx_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE,
  input  logic [7:0] SMR,
  input  logic [7:0] BRR,
  input  logic [7:0] SCR,
  input  logic [7:0] TDR,
  input  logic       TDRE_CLR,
  input  logic       MPBT,
  output logic       TXD,
  output logic       TDRE,
  output logic       TEND,
  output logic       TXI,
  output logic       TEI
);

  SMR_t         smr;
  SCR_t         scr;
  SCI_TxState_t state, nxt, after_data;
  logic [7:0]   shreg;
  logic [2:0]   bit_cnt, last_bit;
  logic         stop_cnt, par_q;
  logic         tdre_q, tend_q, txi_q, tei_q;
  logic         tick, load, fin, shift;
  logic         unused_cfg;

  assign smr      = SMR;
  assign scr      = SCR;
  assign last_bit = smr.chr ? 3'd6 : 3'd7;

`ifdef SCI_TX_MP_EN
  logic mpb_q;
  assign unused_cfg = ^{smr.ca, scr.rie, scr.re, scr.mpie, scr.cke};
`else
  assign unused_cfg = ^{smr.ca, smr.mp, scr.rie, scr.re, scr.mpie, scr.cke, MPBT};
`endif

  sh2_sci_baudgen u_baud (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CE       (CE),
    .CKS      (smr.cks),
    .BRR      (BRR),
    .restart  (load),
    .BIT_TICK (tick)
  );

  always_comb begin
    after_data = smr.pe ? PAR : STOP;
`ifdef SCI_TX_MP_EN
    if (smr.mp) after_data = MPB;
`endif
  end

  // TE=0 aborts regardless of CE; everything else advances on phi ticks only
  always_comb begin
    nxt   = state;
    load  = 1'b0;
    fin   = 1'b0;
    shift = 1'b0;
    if (!scr.te) begin
      nxt = IDLE;
    end else if (CE) begin
      case (state)
        IDLE:  if (!tdre_q) begin load = 1'b1; nxt = START; end
        START: if (tick) nxt = DATA;
        DATA:  if (tick) begin
                 shift = 1'b1;
                 if (bit_cnt == last_bit) nxt = after_data;
               end
        PAR:   if (tick) nxt = STOP;
`ifdef SCI_TX_MP_EN
        MPB:   if (tick) nxt = STOP;
`endif
        STOP:  if (tick && (stop_cnt == smr.stop)) begin
                 if (!tdre_q) begin load = 1'b1; nxt = START; end
                 else begin fin = 1'b1; nxt = IDLE; end
               end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      state <= nxt;
      if (load) begin
        shreg    <= TDR;
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        par_q    <= SCI_Parity(TDR, smr.chr, smr.oe);
      end else if (shift) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end else if (tick && state == STOP) begin
        stop_cnt <= 1'b1;
      end
    end
  end

`ifdef SCI_TX_MP_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    mpb_q <= 1'b0;
    else if (load) mpb_q <= MPBT;
  end
`endif

  // The CPU clear strobe is honoured on any CLK so a write never gets lost between phi ticks
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tdre_q <= 1'b1;
      tend_q <= 1'b1;
      txi_q  <= 1'b0;
      tei_q  <= 1'b0;
    end else begin
      if (!scr.te) begin
        tdre_q <= 1'b1;
        tend_q <= 1'b1;
      end else if (load) begin
        tdre_q <= 1'b1;
        tend_q <= 1'b0;
      end else begin
        if (TDRE_CLR) tdre_q <= 1'b0;
        if (fin)      tend_q <= 1'b1;
      end
      txi_q <= scr.tie & tdre_q;
      tei_q <= scr.teie & tend_q;
    end
  end

  always_comb begin
    TXD = 1'b1;
    case (state)
      START:   TXD = 1'b0;
      DATA:    TXD = shreg[0];
      PAR:     TXD = par_q;
`ifdef SCI_TX_MP_EN
      MPB:     TXD = mpb_q;
`endif
      default: TXD = 1'b1;
    endcase
  end

  assign TDRE = tdre_q;
  assign TEND = tend_q;
  assign TXI  = txi_q;
  assign TEI  = tei_q;

endmodule
